dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter and access sequencer that shares the single-port data memory between two requesters: port 0 is the CPU load/store path and port 1 is a loader/debug port that fills or inspects memory. Requests use a req/gnt handshake. The block drives the memory address, write data and read/write selector, waits a fixed read latency, and returns read data with a one-cycle valid pulse. Arbitration between simultaneous requests is round-robin, and a CPU stall output holds the PC while the CPU access is pending.

## Interface
- WORD_LENGTH, 16, data width in bits.
- ADDR_LENGTH, 16, address width in bits.
- MEM_LATENCY, 1, cycles from address presented to memory data valid. Legal range 1..4.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low. The block resets when reset==0 at a rising edge.
- m0_req / m1_req  in  1  access request. Requester holds it, with we/addr/wdata stable, until it observes gnt.
- m0_we / m1_we  in  1  1 = store, 0 = load.
- m0_addr / m1_addr  in  ADDR_LENGTH  word address.
- m0_wdata / m1_wdata  in  WORD_LENGTH  store data.
- m0_gnt / m1_gnt  out  1  registered, one-cycle pulse. The request has been accepted.
- m0_rvalid / m1_rvalid  out  1  registered, one-cycle pulse. rdata is valid (loads only).
- m0_rdata / m1_rdata  out  WORD_LENGTH  registered load data. Holds its value until the next rvalid for that port.
- mem_addr  out  ADDR_LENGTH  registered address to the data memory.
- mem_wdata  out  WORD_LENGTH  registered write data.
- mem_read_write_selector  out  1  `MEMORY_WRITE` or `MEMORY_READ` encoding from defines.vh.
- mem_rdata  in  WORD_LENGTH  memory read data.
- cpu_stall  out  1  combinational: m0_req & ~m0_gnt & ~m0_rvalid. It is not asserted during a store's gnt cycle.

## Operation
- States: IDLE, WRITE, READ_WAIT, READ_DONE. A latency counter lat_cnt (2 bits) and a last_grant flag (1 bit) complete the state.
- Requests are sampled only at rising edges while in IDLE; req is ignored in every other state.
- Arbitration in IDLE:
  - If only one req is high, that port wins.
  - If both are high, the winner is the port opposite last_grant.
  - last_grant takes the winner's index. Its reset value is 1, so port 0 wins the first tie.
- Grant actions:
  - The winner's addr and wdata are latched into mem_addr and mem_wdata, and its gnt is set for one cycle.
  - A store goes to WRITE with the selector at `MEMORY_WRITE`.
  - A load goes to READ_WAIT with the selector at `MEMORY_READ`, lat_cnt=MEM_LATENCY-1, and the owner recorded.
- WRITE: lasts exactly one cycle. Next state is IDLE, and the selector returns to `MEMORY_READ`.
- READ_WAIT: lat_cnt decrements each cycle. When lat_cnt==0, mem_rdata is captured into the owner's rdata, the owner's rvalid is set, and the state goes to READ_DONE.
- READ_DONE: lasts one cycle (rvalid visible). Next state is IDLE.
- The selector is `MEMORY_WRITE` only while in WRITE, so exactly one write strobe occurs per store.
- Only the owner's gnt and rvalid are ever driven. The other port's gnt and rvalid stay 0.

## Timing
- Reset values:
  - state=IDLE, last_grant=1, lat_cnt=0.
  - All gnt and rvalid = 0, all rdata = 0.
  - mem_addr=0, mem_wdata=0, selector=`MEMORY_READ`.
- Reset mid-access: an in-flight read is dropped with no rvalid, and an in-flight write strobe is cut off at that edge.
- Store: req sampled at edge E → gnt and write strobe in cycle E+1 → IDLE at edge E+1. The requester drops req at edge E+1. The next sample is at edge E+2.
- Load: req sampled at edge E → gnt and address in cycle E+1 → rvalid and rdata in cycle E+1+MEM_LATENCY → IDLE after that cycle.
- Load throughput is therefore one access per MEM_LATENCY+2 cycles. Store throughput is one access per 2 cycles.
- Load latency from req-sampled edge to rvalid is MEM_LATENCY+1 cycles.
- A req that is still high when the arbiter returns to IDLE is treated as a new request.
- Simultaneous requests are served strictly alternately while both stay asserted. No port is starved.

## Test plan
- Reset: hold reset=0 for 3 cycles with both reqs high → gnt/rvalid stay 0, selector=`MEMORY_READ`, mem_addr=0. Release → port 0 is granted first.
- CPU store: m0 store addr=0x0010, wdata=0xBEEF → m0_gnt plus one `MEMORY_WRITE` cycle with mem_addr=0x0010, mem_wdata=0xBEEF. No rvalid. cpu_stall is high only in the cycle before gnt.
- Loads, MEM_LATENCY=1 and 3: m0 load addr=0x0010 with memory returning 0xBEEF → m0_rvalid exactly 2 (or 4) cycles after the req-sampled edge, m0_rdata=0xBEEF, and m0_rdata still 0xBEEF afterwards.
- Contention: both ports request loads continuously → grants alternate 0,1,0,1. Each rvalid appears only on its owner's port.
- Port 1 store then port 0 load to the same address 0x0020 (data 0x1234) → m0_rdata=0x1234.
- Reset asserted during READ_WAIT with MEM_LATENCY=3 → no rvalid is produced, and the next request is granted normally.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//
// Purpose:
//   Bundles the signals around the shared single-port data memory. This
//   covers the two requester ports (CPU load/store path and loader/debug
//   path), the memory-side address/data/selector bus and the CPU stall
//   line. The arbiter connects through the slave modport. Whatever sits on
//   the other side (requesters plus the memory itself) uses the master
//   modport.
//
// Signals:
//   m0_req/m1_req        requester -> arbiter   access request, held until gnt
//   m0_we/m1_we          requester -> arbiter   1 = store, 0 = load
//   m0_addr/m1_addr      requester -> arbiter   word address
//   m0_wdata/m1_wdata    requester -> arbiter   store data
//   m0_gnt/m1_gnt        arbiter -> requester   one-cycle accept pulse
//   m0_rvalid/m1_rvalid  arbiter -> requester   one-cycle load-data-valid pulse
//   m0_rdata/m1_rdata    arbiter -> requester   load data, held until next rvalid
//   mem_addr             arbiter -> memory      registered address
//   mem_wdata            arbiter -> memory      registered write data
//   mem_read_write_selector arbiter -> memory   MEMORY_WRITE / MEMORY_READ
//   mem_rdata            memory -> arbiter      read data
//   cpu_stall            arbiter -> CPU         holds the PC while m0 is pending
// ---------------------------------------------------------------------------

`ifndef MEMORY_WRITE
`define MEMORY_WRITE 1'b1
`endif
`ifndef MEMORY_READ
`define MEMORY_READ 1'b0
`endif

interface dmem_arbiter_if #(
    parameter int WORD_LENGTH = 16,
    parameter int ADDR_LENGTH = 16
) ();

    // Port 0: CPU load/store path
    logic                   m0_req;
    logic                   m0_we;
    logic [ADDR_LENGTH-1:0] m0_addr;
    logic [WORD_LENGTH-1:0] m0_wdata;
    logic                   m0_gnt;
    logic                   m0_rvalid;
    logic [WORD_LENGTH-1:0] m0_rdata;

    // Port 1: loader / debug path
    logic                   m1_req;
    logic                   m1_we;
    logic [ADDR_LENGTH-1:0] m1_addr;
    logic [WORD_LENGTH-1:0] m1_wdata;
    logic                   m1_gnt;
    logic                   m1_rvalid;
    logic [WORD_LENGTH-1:0] m1_rdata;

    // Single-port data memory side
    logic [ADDR_LENGTH-1:0] mem_addr;
    logic [WORD_LENGTH-1:0] mem_wdata;
    logic                   mem_read_write_selector;
    logic [WORD_LENGTH-1:0] mem_rdata;

    // CPU pipeline hold
    logic                   cpu_stall;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_wdata, mem_read_write_selector,
        output cpu_stall
    );

    // Requesters and memory side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_wdata, mem_read_write_selector,
        input  cpu_stall
    );

endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Shares one single-port data memory between two requesters: port 0 is
//   the CPU load/store path and port 1 is the loader/debug path. The block
//   arbitrates round-robin between simultaneous requests and drives a
//   registered address, write data and read/write selector to the memory.
//   For loads it waits MEM_LATENCY cycles and then returns the read data to
//   the owning port with a one-cycle rvalid pulse. While a CPU request is
//   outstanding, cpu_stall holds the PC.
//
// Parameters:
//   WORD_LENGTH  data width in bits
//   ADDR_LENGTH  word address width in bits
//   MEM_LATENCY  cycles from address presented to memory data valid (1..4)
//
// Ports:
//   clk    single clock, all state updates on its rising edge
//   reset  synchronous, active-low; block resets when low at a rising edge
//   bus    dmem_arbiter_if slave modport (requesters, memory, cpu_stall)
// ---------------------------------------------------------------------------

`ifndef MEMORY_WRITE
`define MEMORY_WRITE 1'b1
`endif
`ifndef MEMORY_READ
`define MEMORY_READ 1'b0
`endif

module dmem_arbiter #(
    parameter int WORD_LENGTH = 16,
    parameter int ADDR_LENGTH = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    // Latency counter start value. The counter is two bits wide, which is
    // why MEM_LATENCY is limited to 1..4.
    localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ_DONE
    } state_t;

    state_t                 state_q;
    logic                   lastGrant_q;
    logic                   owner_q;
    logic [1:0]             latCnt_q;

    logic                   m0Gnt_q;
    logic                   m1Gnt_q;
    logic                   m0Rvalid_q;
    logic                   m1Rvalid_q;
    logic [WORD_LENGTH-1:0] m0Rdata_q;
    logic [WORD_LENGTH-1:0] m1Rdata_q;

    logic [ADDR_LENGTH-1:0] memAddr_q;
    logic [WORD_LENGTH-1:0] memWdata_q;
    logic                   memSel_q;

    logic                   anyReq_d;
    logic                   winner_d;
    logic                   winnerWe_d;
    logic [ADDR_LENGTH-1:0] winnerAddr_d;
    logic [WORD_LENGTH-1:0] winnerWdata_d;

    // Arbitration decision for the current cycle. It is only acted on in
    // IDLE. A lone request wins outright. On a tie the port opposite the
    // previous winner is chosen, so both ports alternate while both stay
    // asserted.
    always_comb begin
        anyReq_d = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            winner_d = ~lastGrant_q;
        end else begin
            winner_d = bus.m1_req;
        end
        winnerWe_d    = winner_d ? bus.m1_we    : bus.m0_we;
        winnerAddr_d  = winner_d ? bus.m1_addr  : bus.m0_addr;
        winnerWdata_d = winner_d ? bus.m1_wdata : bus.m0_wdata;
    end

    // Access sequencer. All outputs are registered here. gnt and rvalid
    // default to 0 each cycle, so they can only ever be one-cycle pulses. The
    // selector is raised to MEMORY_WRITE only on the edge that enters WRITE
    // and is dropped on the edge that leaves it, which gives exactly one
    // write strobe per store. A reset in the middle of an access drops it on
    // the spot: no rvalid, and the write strobe ends at that edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            owner_q     <= 1'b0;
            latCnt_q    <= 2'd0;
            m0Gnt_q     <= 1'b0;
            m1Gnt_q     <= 1'b0;
            m0Rvalid_q  <= 1'b0;
            m1Rvalid_q  <= 1'b0;
            m0Rdata_q   <= '0;
            m1Rdata_q   <= '0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            memSel_q    <= `MEMORY_READ;
        end else begin
            m0Gnt_q    <= 1'b0;
            m1Gnt_q    <= 1'b0;
            m0Rvalid_q <= 1'b0;
            m1Rvalid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (anyReq_d) begin
                        lastGrant_q <= winner_d;
                        owner_q     <= winner_d;
                        memAddr_q   <= winnerAddr_d;
                        memWdata_q  <= winnerWdata_d;
                        if (winner_d) begin
                            m1Gnt_q <= 1'b1;
                        end else begin
                            m0Gnt_q <= 1'b1;
                        end
                        if (winnerWe_d) begin
                            state_q  <= WRITE;
                            memSel_q <= `MEMORY_WRITE;
                        end else begin
                            state_q  <= READ_WAIT;
                            memSel_q <= `MEMORY_READ;
                            latCnt_q <= LAT_INIT;
                        end
                    end
                end

                WRITE: begin
                    state_q  <= IDLE;
                    memSel_q <= `MEMORY_READ;
                end

                READ_WAIT: begin
                    // lat_cnt reaching zero means the memory data is valid on
                    // this edge, so it is captured for the owner right away.
                    if (latCnt_q == 2'd0) begin
                        state_q <= READ_DONE;
                        if (owner_q) begin
                            m1Rdata_q  <= bus.mem_rdata;
                            m1Rvalid_q <= 1'b1;
                        end else begin
                            m0Rdata_q  <= bus.mem_rdata;
                            m0Rvalid_q <= 1'b1;
                        end
                    end else begin
                        latCnt_q <= latCnt_q - 2'd1;
                    end
                end

                READ_DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q  <= IDLE;
                    memSel_q <= `MEMORY_READ;
                end
            endcase
        end
    end

    assign bus.m0_gnt                  = m0Gnt_q;
    assign bus.m1_gnt                  = m1Gnt_q;
    assign bus.m0_rvalid               = m0Rvalid_q;
    assign bus.m1_rvalid               = m1Rvalid_q;
    assign bus.m0_rdata                = m0Rdata_q;
    assign bus.m1_rdata                = m1Rdata_q;
    assign bus.mem_addr                = memAddr_q;
    assign bus.mem_wdata               = memWdata_q;
    assign bus.mem_read_write_selector = memSel_q;

    // The stall clears in the gnt cycle (a store is complete then) and in
    // the rvalid cycle (load data is arriving). Everything in between comes
    // from the requester still holding m0_req.
    assign bus.cpu_stall = bus.m0_req & ~m0Gnt_q & ~m0Rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Purpose:
//   Self-checking bench for dmem_arbiter. Two instances run side by side
//   with MEM_LATENCY = 1 (dutA) and MEM_LATENCY = 3 (dutB). Both share one
//   set of requester inputs, and each has its own behavioural memory.
//   Expected grants and load results are queued per instance when stimulus
//   is driven. A negedge monitor pops and compares them as the DUTs
//   respond.
// ---------------------------------------------------------------------------

`ifndef MEMORY_WRITE
`define MEMORY_WRITE 1'b1
`endif
`ifndef MEMORY_READ
`define MEMORY_READ 1'b0
`endif

module tb_dmem_arbiter;

    typedef struct {
        int          port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } gntExp_t;

    typedef struct {
        int          port;
        logic [15:0] data;
    } rdExp_t;

    logic        clk = 1'b0;
    logic        rstA;
    logic        rstB;
    logic        initPhase;
    logic        m0Req, m0We, m1Req, m1We;
    logic [15:0] m0Addr, m0Wdata, m1Addr, m1Wdata;

    logic [15:0] memA   [256];
    logic [15:0] memB   [256];
    logic [15:0] refMem [256];

    gntExp_t     expGntQ [2][$];
    rdExp_t      expRdQ  [2][$];
    logic [15:0] lastRdExp [2][2];
    int          lastGnt [2];
    int          cycle = 0;
    int          testsRun = 0;
    int          failCount = 0;

    dmem_arbiter_if #(.WORD_LENGTH(16), .ADDR_LENGTH(16)) busA ();
    dmem_arbiter_if #(.WORD_LENGTH(16), .ADDR_LENGTH(16)) busB ();

    dmem_arbiter #(.WORD_LENGTH(16), .ADDR_LENGTH(16), .MEM_LATENCY(1)) dutA (
        .clk   (clk),
        .reset (rstA),
        .bus   (busA.slave)
    );

    dmem_arbiter #(.WORD_LENGTH(16), .ADDR_LENGTH(16), .MEM_LATENCY(3)) dutB (
        .clk   (clk),
        .reset (rstB),
        .bus   (busB.slave)
    );

    // Both instances see the same requester activity.
    assign busA.m0_req   = m0Req;
    assign busA.m0_we    = m0We;
    assign busA.m0_addr  = m0Addr;
    assign busA.m0_wdata = m0Wdata;
    assign busA.m1_req   = m1Req;
    assign busA.m1_we    = m1We;
    assign busA.m1_addr  = m1Addr;
    assign busA.m1_wdata = m1Wdata;
    assign busB.m0_req   = m0Req;
    assign busB.m0_we    = m0We;
    assign busB.m0_addr  = m0Addr;
    assign busB.m0_wdata = m0Wdata;
    assign busB.m1_req   = m1Req;
    assign busB.m1_we    = m1We;
    assign busB.m1_addr  = m1Addr;
    assign busB.m1_wdata = m1Wdata;

    // Memory read data is valid as soon as the address is, which satisfies
    // any MEM_LATENCY.
    assign busA.mem_rdata = memA[busA.mem_addr[7:0]];
    assign busB.mem_rdata = memB[busB.mem_addr[7:0]];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural memories: preloaded with a pattern during the first reset,
    // then written on each cycle in which the selector is MEMORY_WRITE.
    always @(posedge clk) begin
        if (initPhase) begin
            for (int i = 0; i < 256; i++) begin
                memA[i] <= 16'(i) ^ 16'hA5A5;
                memB[i] <= 16'(i) ^ 16'hA5A5;
            end
        end else begin
            if (busA.mem_read_write_selector == `MEMORY_WRITE)
                memA[busA.mem_addr[7:0]] <= busA.mem_wdata;
            if (busB.mem_read_write_selector == `MEMORY_WRITE)
                memB[busB.mem_addr[7:0]] <= busB.mem_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Per-instance monitor, called on every falling edge.
    task automatic monitor(input int d, input int lat, input logic rst,
                           input logic g0, input logic g1, input logic rv0, input logic rv1,
                           input logic [15:0] rd0, input logic [15:0] rd1, input logic sel,
                           input logic [15:0] maddr, input logic [15:0] mwdata);
        gntExp_t     ge;
        rdExp_t      re;
        int          p;
        logic        rvP;
        logic [15:0] rdP;
        if (!rst) begin
            lastRdExp[d][0] = 16'h0000;
            lastRdExp[d][1] = 16'h0000;
        end
        if (g0 && g1) checkOutput("gnt_onehot", 32'(g0) + 32'(g1), 1);
        if (g0 || g1) begin
            p = g1 ? 1 : 0;
            if (expGntQ[d].size() == 0) begin
                checkOutput("gnt_unexpected", p, 32'hFF);
            end else begin
                ge = expGntQ[d].pop_front();
                checkOutput("gnt_port", p, ge.port);
                checkOutput("mem_addr", maddr, ge.addr);
                checkOutput("mem_sel", sel, ge.we ? `MEMORY_WRITE : `MEMORY_READ);
                if (ge.we) checkOutput("mem_wdata", mwdata, ge.wdata);
                else lastGnt[d] = cycle;
            end
        end else if (sel == `MEMORY_WRITE) begin
            checkOutput("wr_strobe_extra", sel, `MEMORY_READ);
        end
        for (int q = 0; q < 2; q++) begin
            rvP = (q == 1) ? rv1 : rv0;
            rdP = (q == 1) ? rd1 : rd0;
            if (rvP) begin
                if (expRdQ[d].size() == 0) begin
                    checkOutput("rv_unexpected", q, 32'hFF);
                end else begin
                    re = expRdQ[d].pop_front();
                    checkOutput("rv_port", q, re.port);
                    checkOutput("rdata", rdP, re.data);
                    checkOutput("rd_latency", cycle - lastGnt[d], lat);
                    lastRdExp[d][q] = re.data;
                end
            end else begin
                checkOutput("rdata_hold", rdP, lastRdExp[d][q]);
            end
        end
    endtask

    always @(negedge clk)
        monitor(0, 1, rstA, busA.m0_gnt, busA.m1_gnt, busA.m0_rvalid, busA.m1_rvalid,
                busA.m0_rdata, busA.m1_rdata, busA.mem_read_write_selector,
                busA.mem_addr, busA.mem_wdata);

    always @(negedge clk)
        monitor(1, 3, rstB, busB.m0_gnt, busB.m1_gnt, busB.m0_rvalid, busB.m1_rvalid,
                busB.m0_rdata, busB.m1_rdata, busB.mem_read_write_selector,
                busB.mem_addr, busB.mem_wdata);

    // Queue one expected grant (and, for loads, its result) on one instance.
    task automatic pushOne(input int d, input int port, input logic we,
                           input logic [15:0] addr, input logic [15:0] wdata);
        gntExp_t ge;
        rdExp_t  re;
        ge.port  = port;
        ge.we    = we;
        ge.addr  = addr;
        ge.wdata = wdata;
        expGntQ[d].push_back(ge);
        if (!we) begin
            re.port = port;
            re.data = refMem[addr[7:0]];
            expRdQ[d].push_back(re);
        end
    endtask

    task automatic driveReq(input int port, input logic we, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic req);
        if (port == 0) begin
            m0We = we; m0Addr = addr; m0Wdata = wdata; m0Req = req;
        end else begin
            m1We = we; m1Addr = addr; m1Wdata = wdata; m1Req = req;
        end
    endtask

    function automatic logic gntOf(input int d, input int port);
        if (d == 0) return (port == 0) ? busA.m0_gnt : busA.m1_gnt;
        return (port == 0) ? busB.m0_gnt : busB.m1_gnt;
    endfunction

    task automatic waitBothGnt(input int port);
        bit found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gntOf(0, port) && gntOf(1, port)) begin
                found = 1;
                break;
            end
        end
        if (!found) checkOutput("gnt_timeout", 0, 1);
    endtask

    // One request on one port. If resetB is set, dutB is reset in the
    // cycle after the grant, which drops its in-flight access.
    task automatic applyStimulus(input int port, input logic we, input logic [15:0] addr,
                                 input logic [15:0] wdata, input bit resetB);
        @(posedge clk);
        #1;
        pushOne(0, port, we, addr, wdata);
        if (!resetB) pushOne(1, port, we, addr, wdata);
        else begin
            pushOne(1, port, 1'b1, addr, wdata);
            void'(expGntQ[1].pop_back());
            pushOne(1, port, we, addr, wdata);
            if (!we) void'(expRdQ[1].pop_back());
        end
        if (we) refMem[addr[7:0]] = wdata;
        driveReq(port, we, addr, wdata, 1'b1);
        @(negedge clk);
        if (port == 0) checkOutput("stall_pre", {busA.cpu_stall, busB.cpu_stall}, 2'b11);
        waitBothGnt(port);
        if (port == 0) checkOutput("stall_gnt", {busA.cpu_stall, busB.cpu_stall}, 2'b00);
        #1;
        driveReq(port, we, addr, wdata, 1'b0);
        if (resetB) begin
            rstB = 1'b0;
            @(negedge clk);
            #1 rstB = 1'b1;
        end
        if (port == 0) begin
            @(negedge clk);
            checkOutput("stall_post", {busA.cpu_stall, busB.cpu_stall}, 2'b00);
        end
        repeat (8) @(negedge clk);
    endtask

    // Both ports request loads continuously. dutB (5-cycle period) reaches
    // its 4th grant on the same edge as dutA (3-cycle period) reaches its
    // 6th, and the requests are dropped right there.
    task automatic contention();
        int nB = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) pushOne(0, k % 2, 1'b0, (k % 2) ? 16'h0030 : 16'h0010, 16'h0);
        for (int k = 0; k < 4; k++) pushOne(1, k % 2, 1'b0, (k % 2) ? 16'h0030 : 16'h0010, 16'h0);
        driveReq(0, 1'b0, 16'h0010, 16'h0, 1'b1);
        driveReq(1, 1'b0, 16'h0030, 16'h0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busB.m0_gnt || busB.m1_gnt) nB++;
            if (nB == 4) break;
        end
        if (nB != 4) checkOutput("cont_timeout", nB, 4);
        #1;
        driveReq(0, 1'b0, 16'h0010, 16'h0, 1'b0);
        driveReq(1, 1'b0, 16'h0030, 16'h0, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rstA = 1'b0;
        rstB = 1'b0;
        initPhase = 1'b1;
        for (int i = 0; i < 256; i++) refMem[i] = 16'(i) ^ 16'hA5A5;
        // Both ports request through reset. Nothing may be granted.
        driveReq(0, 1'b0, 16'h0010, 16'h0, 1'b1);
        driveReq(1, 1'b0, 16'h0030, 16'h0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_pulses_A", {busA.m0_gnt, busA.m1_gnt, busA.m0_rvalid, busA.m1_rvalid}, 0);
            checkOutput("rst_pulses_B", {busB.m0_gnt, busB.m1_gnt, busB.m0_rvalid, busB.m1_rvalid}, 0);
            checkOutput("rst_sel_A", busA.mem_read_write_selector, `MEMORY_READ);
            checkOutput("rst_sel_B", busB.mem_read_write_selector, `MEMORY_READ);
            checkOutput("rst_addr_A", busA.mem_addr, 0);
            checkOutput("rst_addr_B", busB.mem_addr, 0);
        end
        // On release, port 0 wins the first tie.
        pushOne(0, 0, 1'b0, 16'h0010, 16'h0);
        pushOne(1, 0, 1'b0, 16'h0010, 16'h0);
        #1;
        rstA = 1'b1;
        rstB = 1'b1;
        initPhase = 1'b0;
        waitBothGnt(0);
        #1;
        m0Req = 1'b0;
        m1Req = 1'b0;
        repeat (8) @(negedge clk);

        applyStimulus(0, 1'b1, 16'h0010, 16'hBEEF, 0);   // CPU store
        applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 0);   // CPU load of it
        applyStimulus(1, 1'b1, 16'h0020, 16'h1234, 0);   // loader store
        applyStimulus(0, 1'b0, 16'h0020, 16'h0000, 0);   // CPU load same address
        applyStimulus(1, 1'b1, 16'h0030, 16'h5A5A, 0);   // loader store
        contention();
        applyStimulus(0, 1'b0, 16'h0020, 16'h0000, 1);   // dutB reset in READ_WAIT
        applyStimulus(1, 1'b0, 16'h0030, 16'h0000, 0);   // normal service afterwards

        for (int d = 0; d < 2; d++) begin
            checkOutput("gnt_q_drain", expGntQ[d].size(), 0);
            checkOutput("rd_q_drain", expRdQ[d].size(), 0);
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
